// File: rtl/hin_isa_pkg.sv
// Shared ISA definitions for the HIN instruction encoder/decoder pair:
// opcodes, field positions, word packing and legality check.
package hin_isa_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_NEW  = 4'h1;
  localparam logic [3:0] OP_LINK = 4'h2;
  localparam logic [3:0] OP_EVAL = 4'h5;

  localparam int OP_LSB   = 12;
  localparam int DEST_LSB = 8;
  localparam int SRC1_LSB = 4;
  localparam int SRC2_LSB = 0;

  typedef enum logic [1:0] {ST_IDLE, ST_CH_NEW, ST_CH_LINK, ST_CH_EVAL} enc_state_e;

  function automatic logic [15:0] pack_instr(input logic [3:0] op, input logic [3:0] dest,
                                             input logic [3:0] src1, input logic [3:0] src2);
    logic [15:0] w;
    w = '0;
    w[OP_LSB+:4]   = op;
    w[DEST_LSB+:4] = dest;
    w[SRC1_LSB+:4] = src1;
    w[SRC2_LSB+:4] = src2;
    return w;
  endfunction

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == OP_NOP) || (op == OP_NEW) || (op == OP_LINK) || (op == OP_EVAL);
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with registered storage; head entry is presented
// combinationally and reads as zero while empty.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs single commands and expands CHAIN macros into NEW/LINK/EVAL
// instruction words, buffered through instr_fifo toward the fetch path.
module instr_encoder
  import hin_isa_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_chain,
  input  logic [3:0]       cmd_op,
  input  logic [3:0]       cmd_dest,
  input  logic [3:0]       cmd_src1,
  input  logic [3:0]       cmd_src2,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [15:0]      instr,
  output logic             busy,
  output logic             err_illegal,
  output logic [ERR_W-1:0] err_count
);
  enc_state_e       state_q, state_d;
  logic [3:0]       b_q, b_d, n_q, n_d, i_q, i_d;
  logic [3:0]       node_i, node_i1;
  logic             push, rej, full, empty, acc;
  logic [15:0]      push_data;
  logic             err_q;
  logic [ERR_W-1:0] err_cnt_q;

  assign cmd_ready   = (state_q == ST_IDLE) && !full;
  assign acc         = cmd_valid && cmd_ready;
  assign node_i      = b_q + i_q;
  assign node_i1     = node_i + 4'd1;
  assign busy        = (state_q != ST_IDLE) || !empty;
  assign instr_valid = !empty;
  assign err_illegal = err_q;
  assign err_count   = err_cnt_q;

  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    n_d       = n_q;
    i_d       = i_q;
    push      = 1'b0;
    push_data = '0;
    rej       = 1'b0;
    case (state_q)
      ST_IDLE: if (acc) begin
        if (cmd_chain) begin
          if (cmd_src1 == 4'd0) rej = 1'b1;
          else begin
            b_d     = cmd_dest;
            n_d     = cmd_src1;
            i_d     = 4'd0;
            state_d = ST_CH_NEW;
          end
        end else if (is_legal_op(cmd_op)) begin
          push      = 1'b1;
          push_data = pack_instr(cmd_op, cmd_dest, cmd_src1, cmd_src2);
        end else rej = 1'b1;
      end
      ST_CH_NEW: if (!full) begin
        push      = 1'b1;
        push_data = pack_instr(OP_NEW, node_i, 4'd0, 4'd0);
        if (i_q == n_q - 4'd1) begin
          i_d     = 4'd0;
          state_d = (n_q == 4'd1) ? ST_CH_EVAL : ST_CH_LINK;
        end else i_d = i_q + 4'd1;
      end
      ST_CH_LINK: if (!full) begin
        push      = 1'b1;
        push_data = pack_instr(OP_LINK, node_i, node_i1, 4'd0);
        if (i_q == n_q - 4'd2) state_d = ST_CH_EVAL;
        else                   i_d     = i_q + 4'd1;
      end
      ST_CH_EVAL: if (!full) begin
        push      = 1'b1;
        push_data = pack_instr(OP_EVAL, b_q, 4'd0, 4'd0);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      b_q       <= '0;
      n_q       <= '0;
      i_q       <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      n_q     <= n_d;
      i_q     <= i_d;
      err_q   <= rej;
      if (rej && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + ERR_W'(1);
    end
  end

  instr_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .data_i (push_data),
    .pop_i  (instr_ready),
    .full_o (full),
    .empty_o(empty),
    .head_o (instr)
  );

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: table of single/illegal commands plus
// CHAIN, backpressure, saturation and reset-abort sequences.
module tb_instr_encoder;
  logic        clk = 0, rst_n = 0;
  logic        cmd_valid = 0, cmd_chain = 0, instr_ready = 1;
  logic [3:0]  cmd_op = 0, cmd_dest = 0, cmd_src1 = 0, cmd_src2 = 0;
  logic        cmd_ready, instr_valid, busy, err_illegal;
  logic [15:0] instr;
  logic [7:0]  err_count;

  logic        c2_valid = 0, c2_ready, c2_ivalid, c2_busy, c2_err;
  logic [15:0] c2_instr;
  logic [1:0]  c2_cnt;

  int total = 0, bad = 0, errs = 0;
  logic [15:0] got[$];

  always #5 clk = ~clk;

  instr_encoder #(.FIFO_DEPTH(4), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_chain(cmd_chain), .cmd_op(cmd_op), .cmd_dest(cmd_dest), .cmd_src1(cmd_src1),
    .cmd_src2(cmd_src2), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .busy(busy), .err_illegal(err_illegal), .err_count(err_count));

  instr_encoder #(.FIFO_DEPTH(4), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
    .cmd_chain(1'b0), .cmd_op(4'h7), .cmd_dest(4'h0), .cmd_src1(4'h0),
    .cmd_src2(4'h0), .instr_valid(c2_ivalid), .instr_ready(1'b1),
    .instr(c2_instr), .busy(c2_busy), .err_illegal(c2_err), .err_count(c2_cnt));

  always @(posedge clk)
    if (rst_n && instr_valid && instr_ready) got.push_back(instr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic ch, input logic [3:0] op, input logic [3:0] d,
                      input logic [3:0] s1, input logic [3:0] s2);
    int n;
    n = 0;
    cmd_chain = ch; cmd_op = op; cmd_dest = d; cmd_src1 = s1; cmd_src2 = s2;
    cmd_valid = 1;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      if (++n > 200) begin chk("accept_timeout", 0, 1); break; end
    end
    @(posedge clk); #1 cmd_valid = 0;
  endtask

  typedef struct {
    logic ch; logic [3:0] op, d, s1, s2;
    logic exp_err; logic [15:0] exp_word;
  } vec_t;
  vec_t vt[7];

  logic [15:0] chain_exp[6] = '{16'h1200, 16'h1300, 16'h1400, 16'h2230, 16'h2340, 16'h5200};
  logic [15:0] bp_exp[5]    = '{16'h1100, 16'h2120, 16'h5300, 16'h0456, 16'h1900};
  logic [15:0] wrap_exp[4]  = '{16'h1F00, 16'h1000, 16'h2F00, 16'h5F00};

  initial begin
    vt[0] = '{1'b0, 4'h1, 4'h3, 4'h0, 4'h0, 1'b0, 16'h1300};
    vt[1] = '{1'b0, 4'h2, 4'h1, 4'h2, 4'h0, 1'b0, 16'h2120};
    vt[2] = '{1'b0, 4'h7, 4'h1, 4'h2, 4'h3, 1'b1, 16'h0000};
    vt[3] = '{1'b1, 4'h0, 4'h5, 4'h0, 4'h0, 1'b1, 16'h0000};
    vt[4] = '{1'b0, 4'h5, 4'hA, 4'h0, 4'h0, 1'b0, 16'h5A00};
    vt[5] = '{1'b0, 4'h0, 4'h1, 4'h2, 4'h3, 1'b0, 16'h0123};
    vt[6] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 16'h0000};

    // reset state
    #12;
    chk("rst_valid", instr_valid, 0); chk("rst_instr", instr, 0);
    chk("rst_err", err_illegal, 0);   chk("rst_cnt", err_count, 0);
    chk("rst_busy", busy, 0);         chk("rst_ready", cmd_ready, 1);
    @(posedge clk); #1 rst_n = 1;

    foreach (vt[k]) begin
      got.delete();
      send(vt[k].ch, vt[k].op, vt[k].d, vt[k].s1, vt[k].s2);
      chk($sformatf("v%0d_errpulse", k), err_illegal, vt[k].exp_err);
      if (!vt[k].exp_err) begin
        chk($sformatf("v%0d_valid_t1", k), instr_valid, 1);
        chk($sformatf("v%0d_word", k), instr, vt[k].exp_word);
      end
      errs += int'(vt[k].exp_err);
      chk($sformatf("v%0d_errcnt", k), err_count, errs);
      repeat (3) @(posedge clk); #1;
      chk($sformatf("v%0d_nwords", k), got.size(), vt[k].exp_err ? 0 : 1);
      if (!vt[k].exp_err && got.size() == 1) chk($sformatf("v%0d_drained", k), got[0], vt[k].exp_word);
      chk($sformatf("v%0d_busy", k), busy, 0);
      chk($sformatf("v%0d_errdone", k), err_illegal, 0);
    end

    // CHAIN b=2 n=3: first word at t+2, cmd_ready low for 2n cycles
    begin
      int lows;
      lows = 0;
      got.delete();
      send(1'b1, 4'h0, 4'h2, 4'h3, 4'h0);
      chk("chain_valid_t1", instr_valid, 0);
      forever begin
        @(negedge clk);
        if (cmd_ready) break;
        lows++;
        if (lows == 1) chk("chain_latch_cycle", instr_valid, 0);
        if (lows == 2) begin
          chk("chain_valid_t2", instr_valid, 1);
          chk("chain_first", instr, 16'h1200);
        end
        if (lows > 50) begin chk("chain_timeout", 0, 1); break; end
      end
      chk("chain_ready_low", lows, 6);
      repeat (4) @(posedge clk); #1;
      chk("chain_nwords", got.size(), 6);
      foreach (chain_exp[k]) if (k < got.size()) chk($sformatf("chain_w%0d", k), got[k], chain_exp[k]);
      chk("chain_busy", busy, 0);
    end

    // backpressure: 4 fills the FIFO, 5th is held until drain
    got.delete();
    instr_ready = 0;
    for (int k = 0; k < 4; k++)
      send(1'b0, bp_exp[k][15:12], bp_exp[k][11:8], bp_exp[k][7:4], bp_exp[k][3:0]);
    chk("bp_ready_full", cmd_ready, 0);
    chk("bp_head", instr, bp_exp[0]);
    cmd_op = bp_exp[4][15:12]; cmd_dest = bp_exp[4][11:8];
    cmd_src1 = bp_exp[4][7:4]; cmd_src2 = bp_exp[4][3:0]; cmd_chain = 0; cmd_valid = 1;
    repeat (3) @(posedge clk); #1;
    chk("bp_held_ready", cmd_ready, 0);
    chk("bp_held_head", instr, bp_exp[0]);
    chk("bp_held_valid", instr_valid, 1);
    instr_ready = 1;
    send(1'b0, bp_exp[4][15:12], bp_exp[4][11:8], bp_exp[4][7:4], bp_exp[4][3:0]);
    repeat (6) @(posedge clk); #1;
    chk("bp_nwords", got.size(), 5);
    foreach (bp_exp[k]) if (k < got.size()) chk($sformatf("bp_w%0d", k), got[k], bp_exp[k]);

    // saturation on the ERR_W=2 instance
    c2_valid = 1;
    repeat (5) @(posedge clk); #1 c2_valid = 0;
    chk("sat_pulse", c2_err, 1);
    chk("sat_count", c2_cnt, 3);
    chk("sat_nowords", c2_ivalid, 0);
    @(posedge clk); #1;
    chk("sat_pulse_end", c2_err, 0);

    // node wrap b=F n=2
    got.delete();
    send(1'b1, 4'h0, 4'hF, 4'h2, 4'h0);
    repeat (8) @(posedge clk); #1;
    chk("wrap_nwords", got.size(), 4);
    foreach (wrap_exp[k]) if (k < got.size()) chk($sformatf("wrap_w%0d", k), got[k], wrap_exp[k]);

    // reset mid-CHAIN after 2nd word
    got.delete();
    send(1'b1, 4'h0, 4'hF, 4'h2, 4'h0);
    begin
      int n;
      n = 0;
      while (got.size() < 2 && n < 50) begin @(negedge clk); n++; end
      chk("rst_mid_reach", got.size(), 2);
    end
    rst_n = 0; #1;
    chk("rstm_valid", instr_valid, 0); chk("rstm_instr", instr, 0);
    chk("rstm_busy", busy, 0);         chk("rstm_ready", cmd_ready, 1);
    chk("rstm_cnt", err_count, 0);
    @(posedge clk); #1 rst_n = 1;
    repeat (2) @(posedge clk); #1;
    chk("rstm_no_leak", got.size(), 2);
    got.delete();
    send(1'b0, 4'h1, 4'h7, 4'h0, 4'h0);
    chk("post_rst_valid", instr_valid, 1);
    chk("post_rst_word", instr, 16'h1700);
    repeat (3) @(posedge clk); #1;
    chk("post_rst_nwords", got.size(), 1);
    chk("post_rst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
